reg_bank_8: RTL
===============

REG_BANK_8 -- requirements
Module: reg_bank_8

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter ZERO_REG_EN, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe.
REQ-006 wr_addr  input  3  write register index.
REQ-007 wr_data  input  WIDTH  write data.
REQ-008 rsv_en  input  1  reserve strobe: mark wr target pending.
REQ-009 rsv_addr  input  3  register index to reserve.
REQ-010 rd_req  input  1  read request, both ports.
REQ-011 rd_addr_a / rd_addr_b  input  3 each  read indices.
REQ-012 rd_data_a / rd_data_b  output  WIDTH each  registered read data.
REQ-013 rd_valid  output  1  read data valid, one cycle.
REQ-014 rd_stall  output  1  combinational: request blocked by pending register.
REQ-015 pending  output  8  scoreboard bit per register.

Function
REQ-016 Write: on wr_en, reg[wr_addr] <= wr_data at the next edge; pending[wr_addr] cleared at that same edge.
REQ-017 Reserve: on rsv_en, pending[rsv_addr] set at the next edge; rsv_en and wr_en to the same index in one cycle -> pending ends set (reserve wins).
REQ-018 With ZERO_REG_EN=1: writes/reserves to index 0 are discarded; pending[0] is always 0; reads of 0 return 0.
REQ-019 rd_stall = rd_req AND (pending[rd_addr_a] OR pending[rd_addr_b]), excluding a pending bit being cleared by a same-cycle wr_en only when bypass is compiled in (see REQ-027).
REQ-020 Read accepted when rd_req=1 and rd_stall=0; rd_data_a/b and rd_valid=1 presented the following cycle (latency 1).
REQ-021 rd_valid is high for exactly one cycle per accepted read; back-to-back accepted reads give continuous rd_valid.
REQ-022 rd_data_a/b hold their last value when no read is accepted.
REQ-023 Without bypass, a read accepted in the same cycle as a write to the same index returns the old value.
REQ-024 rd_addr_a = rd_addr_b is legal; both outputs equal.

Reset
REQ-025 On reset: all registers 0, pending = 8'h00, rd_data_a/b = 0, rd_valid = 0; reset overrides wr_en, rsv_en and rd_req in the same cycle.
REQ-026 Reset mid-operation: an accepted read in the reset cycle does not produce rd_valid.

Configuration
REQ-027 Macro REG_BANK_BYPASS_EN: defined -> same-cycle wr_en data forwarded to an accepted read of wr_addr, and a pending bit being cleared by that write does not stall; undefined -> REQ-023 behaviour, stall on any set pending bit.

Structure
REQ-028 Shared package holds REG_ADDR_W = 3, REG_COUNT = 8, ZERO_REG = 3'd0.
REQ-029 One sub-module, reg_bank_read_port, instantiated twice: 8:1 WIDTH-wide select, optional bypass, output register.

Verification
REQ-030 Reset, then read indices 3/5 -> rd_valid one cycle later, both data 0, pending 8'h00.
REQ-031 Write 32'hDEADBEEF to 4, next cycle read a=4 b=0 -> next cycle rd_data_a=32'hDEADBEEF, rd_data_b=0; write 32'h1 to 0 leaves reg 0 reading 0.
REQ-032 Reserve 6, then read a=6 -> rd_stall=1, no rd_valid; write 32'h55 to 6 -> pending[6]=0, retried read returns 32'h55.
REQ-033 Same cycle write 32'hA5A5 to 2 and read a=2 (prior 32'h0) -> returns 32'h0 without REG_BANK_BYPASS_EN, 32'hA5A5 with it.
REQ-034 Same-cycle rsv_en and wr_en on index 7 -> pending[7]=1 afterwards, reg[7] holds wr_data.
REQ-035 Assert reset during accepted read with pending 8'h0C -> next cycle rd_valid=0, pending=8'h00, outputs 0.

Source files
------------

// File: rtl/reg_bank_8_pkg.sv
// Shared constants for the 8-entry register bank with a pending scoreboard.
package reg_bank_8_pkg;
   localparam int                  REG_ADDR_W = 3;
   localparam int                  REG_COUNT  = 8;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 3'd0;
endpackage

// File: rtl/reg_bank_read_port.sv
// One read port: 8:1 register select, optional same-cycle write forwarding,
// and an output register that only loads on an accepted read.
import reg_bank_8_pkg::*;

module reg_bank_read_port #(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b0
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                load,
   input  logic [REG_ADDR_W-1:0]               addr,
   input  logic [REG_COUNT-1:0][WIDTH-1:0]     regs,
   input  logic                                byp_en,
   input  logic [REG_ADDR_W-1:0]               byp_addr,
   input  logic [WIDTH-1:0]                    byp_data,
   output logic [WIDTH-1:0]                    rd_data
);

   logic [WIDTH-1:0] sel_data;

   // Pick the stored value, or the in-flight write data when forwarding is built in.
   always_comb begin
      sel_data = regs[addr];
      if (BYPASS && byp_en && (byp_addr == addr)) begin
         sel_data = byp_data;
      end
   end

   // Output register holds its value until the next accepted read.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= '0;
      end else if (load) begin
         rd_data <= sel_data;
      end
   end

endmodule

// File: rtl/reg_bank_8.sv
// 8-entry register bank with a per-register pending scoreboard and two
// registered read ports that stall while a requested register is pending.
// Optional feature macro: REG_BANK_BYPASS_EN (forward same-cycle write data
// to an accepted read and let that write's pending clear lift the stall).
// Handshake: a read is accepted on a cycle with rd_req=1 and rd_stall=0;
// rd_valid pulses for exactly one cycle on the next cycle with the data.
import reg_bank_8_pkg::*;

module reg_bank_8 #(
   parameter int WIDTH       = 32,
   parameter int ZERO_REG_EN = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [REG_ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rsv_en,
   input  logic [REG_ADDR_W-1:0] rsv_addr,
   input  logic                  rd_req,
   input  logic [REG_ADDR_W-1:0] rd_addr_a,
   input  logic [REG_ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]      rd_data_a,
   output logic [WIDTH-1:0]      rd_data_b,
   output logic                  rd_valid,
   output logic                  rd_stall,
   output logic [REG_COUNT-1:0]  pending
);

`ifdef REG_BANK_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [REG_COUNT-1:0][WIDTH-1:0] regs;
   logic [REG_COUNT-1:0]            pend_q;
   logic [REG_COUNT-1:0]            pend_nxt;
   logic [REG_COUNT-1:0]            pend_vis;
   logic                            wr_ok;
   logic                            rsv_ok;
   logic                            rd_accept;

   // Register 0 swallows writes and reserves when it is hard-wired to zero.
   assign wr_ok  = wr_en  && !((ZERO_REG_EN != 0) && (wr_addr  == ZERO_REG));
   assign rsv_ok = rsv_en && !((ZERO_REG_EN != 0) && (rsv_addr == ZERO_REG));

   // Register file storage.
   always_ff @(posedge clock) begin
      if (reset) begin
         regs <= '0;
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Next scoreboard: a write clears its bit, a reserve sets its bit and wins a tie.
   always_comb begin
      pend_nxt = pend_q;
      if (wr_ok) begin
         pend_nxt[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
         pend_nxt[rsv_addr] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_nxt;
      end
   end

   // Pending bits as seen by the stall check; with forwarding, a register being
   // written this cycle is already resolved.
   always_comb begin
      pend_vis = pend_q;
      if (BYPASS && wr_ok) begin
         pend_vis[wr_addr] = 1'b0;
      end
   end

   assign rd_stall  = rd_req && (pend_vis[rd_addr_a] || pend_vis[rd_addr_b]);
   assign rd_accept = rd_req && !rd_stall;
   assign pending   = pend_q;

   // One-cycle valid pulse per accepted read; reset suppresses it.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_accept;
      end
   end

   reg_bank_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_a (
      .clock    (clock),
      .reset    (reset),
      .load     (rd_accept),
      .addr     (rd_addr_a),
      .regs     (regs),
      .byp_en   (wr_ok),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .rd_data  (rd_data_a)
   );

   reg_bank_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) u_port_b (
      .clock    (clock),
      .reset    (reset),
      .load     (rd_accept),
      .addr     (rd_addr_b),
      .regs     (regs),
      .byp_en   (wr_ok),
      .byp_addr (wr_addr),
      .byp_data (wr_data),
      .rd_data  (rd_data_b)
   );

endmodule
